// File: rtl/mem_arb_pkg.sv
// Shared widths and FSM state type for the two-port arbitrated memory.
package mem_arb_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic {ST_INIT, ST_READY} state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered priority pointer.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic a_req,
  input  logic b_req,
  output logic a_gnt,
  output logic b_gnt
);
  // ptr_b = 1 means B wins the next contended cycle
  logic ptr_b;

  always_comb begin
    a_gnt = en & a_req & (~b_req | ~ptr_b);
    b_gnt = en & b_req & (~a_req | ptr_b);
  end

  always_ff @(posedge clk) begin
    if (rst)        ptr_b <= 1'b0;
    else if (a_gnt) ptr_b <= 1'b1;
    else if (b_gnt) ptr_b <= 1'b0;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Single storage array shared by two requesters; cleared after reset, then
// accessed through a round-robin arbiter with one-cycle read latency.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int ADDR_W_P = ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_req,
  input  logic                a_we,
  input  logic [ADDR_W_P-1:0] a_addr,
  input  logic [DATA_W_P-1:0] a_din,
  output logic                a_gnt,
  output logic                a_rvalid,
  output logic [DATA_W_P-1:0] a_rdata,
  input  logic                b_req,
  input  logic                b_we,
  input  logic [ADDR_W_P-1:0] b_addr,
  input  logic [DATA_W_P-1:0] b_din,
  output logic                b_gnt,
  output logic                b_rvalid,
  output logic [DATA_W_P-1:0] b_rdata,
  output logic                init_done
);
  localparam int DEPTH_P = 1 << ADDR_W_P;

  state_t              state;
  logic [ADDR_W_P-1:0] init_cnt;
  logic [DATA_W_P-1:0] mem [DEPTH_P];

  logic                arb_en;
  logic                wr_en;
  logic [ADDR_W_P-1:0] wr_addr;
  logic [DATA_W_P-1:0] wr_data;

  // Grants are suppressed while reset is asserted so nothing is accepted at a reset edge
  assign arb_en = (state == ST_READY) & ~rst;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (arb_en),
    .a_req (a_req),
    .b_req (b_req),
    .a_gnt (a_gnt),
    .b_gnt (b_gnt)
  );

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = init_cnt;
    wr_data = '0;
    if (state == ST_INIT && !rst) begin
      wr_en = 1'b1;
    end else if (a_gnt) begin
      wr_en   = a_we;
      wr_addr = a_addr;
      wr_data = a_din;
    end else if (b_gnt) begin
      wr_en   = b_we;
      wr_addr = b_addr;
      wr_data = b_din;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == ADDR_W_P'(DEPTH_P - 1)) begin
            state     <= ST_READY;
            init_done <= 1'b1;
          end
        end
        default: state <= ST_READY;
      endcase
    end
  end

  // Read data registers hold their value between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= a_gnt & ~a_we;
      b_rvalid <= b_gnt & ~b_we;
      if (a_gnt && !a_we) a_rdata <= mem[a_addr];
      if (b_gnt && !b_we) b_rdata <= mem[b_addr];
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: init latency, writes/reads, contention, reset abort.
module tb_mem_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [2:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_din = '0, b_din = '0;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid, init_done;
  logic [7:0] a_rdata, b_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_din    (a_din),
    .a_gnt    (a_gnt),
    .a_rvalid (a_rvalid),
    .a_rdata  (a_rdata),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_din    (b_din),
    .b_gnt    (b_gnt),
    .b_rvalid (b_rvalid),
    .b_rdata  (b_rdata),
    .init_done(init_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Counts edges from the reset edge (inclusive) until init_done is seen high;
  // checks a_gnt stays low throughout the clear sequence.
  task automatic wait_init(output int n);
    n = 1;
    rst = 1'b0;
    while (!init_done && n < 20) begin
      check("init_no_gnt", {30'd0, a_gnt, b_gnt}, 32'd0);
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    logic [7:0] expd;

    // Reset held for one edge, all requesters idle
    @(negedge clk);
    check("rst_init_done", init_done, 0);
    check("rst_rvalid", {a_rvalid, b_rvalid}, 0);
    check("rst_rdata", {a_rdata, b_rdata}, 0);
    wait_init(n);
    check("init_latency", n, 9);

    // Contention from reset: A first, then alternating
    a_req = 1; a_we = 0; a_addr = 0;
    b_req = 1; b_we = 0; b_addr = 1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("rr_a_%0d", k), a_gnt, (k % 2 == 0));
      check($sformatf("rr_b_%0d", k), b_gnt, (k % 2 == 1));
      @(negedge clk);
    end
    a_req = 0; b_req = 0;
    @(negedge clk);

    // All words cleared
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        check($sformatf("clr_rvalid_%0d", i - 1), a_rvalid, 1);
        check($sformatf("clr_rdata_%0d", i - 1), a_rdata, 8'h00);
      end
      if (i < 8) begin
        a_req = 1; a_we = 0; a_addr = 3'(i);
        #1 check($sformatf("clr_gnt_%0d", i), a_gnt, 1);
      end else a_req = 0;
      @(negedge clk);
    end

    // Back-to-back writes from A
    for (int i = 0; i < 8; i++) begin
      a_req = 1; a_we = 1; a_addr = 3'(i); a_din = 8'(i * 16 + 5);
      #1 check($sformatf("wr_gnt_%0d", i), a_gnt, 1);
      @(negedge clk);
      check($sformatf("wr_no_rvalid_%0d", i), a_rvalid, 0);
    end
    // Back-to-back reads, data one cycle after each grant
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        expd = 8'((i - 1) * 16 + 5);
        check($sformatf("rd_rvalid_%0d", i - 1), a_rvalid, 1);
        check($sformatf("rd_rdata_%0d", i - 1), a_rdata, expd);
      end
      if (i < 8) begin
        a_req = 1; a_we = 0; a_addr = 3'(i);
        #1 check($sformatf("rd_gnt_%0d", i), a_gnt, 1);
      end else a_req = 0;
      @(negedge clk);
    end
    check("hold_rvalid", a_rvalid, 0);
    check("hold_rdata", a_rdata, 8'h75);

    // A writes 0xAA to addr 3, B reads it the following cycle
    a_req = 1; a_we = 1; a_addr = 3; a_din = 8'hAA;
    #1 check("raw_a_gnt", a_gnt, 1);
    @(negedge clk);
    a_req = 0; b_req = 1; b_we = 0; b_addr = 3;
    #1 check("raw_b_gnt", b_gnt, 1);
    @(negedge clk);
    b_req = 0;
    check("raw_b_rvalid", b_rvalid, 1);
    check("raw_b_rdata", b_rdata, 8'hAA);
    check("raw_a_rvalid", a_rvalid, 0);

    // Read granted, then reset on the next edge
    a_req = 1; a_we = 0; a_addr = 5;
    #1 check("abort_gnt", a_gnt, 1);
    @(negedge clk);
    check("abort_pre_rvalid", a_rvalid, 1);
    check("abort_pre_rdata", a_rdata, 8'h55);
    rst = 1; a_addr = 3;
    #1 check("abort_rst_gnt", a_gnt, 0);
    @(negedge clk);
    check("abort_rvalid", a_rvalid, 0);
    check("abort_rdata", a_rdata, 8'h00);
    check("abort_init_done", init_done, 0);
    // a_req stays high through the re-clear
    wait_init(n);
    check("reinit_latency", n, 9);
    check("first_ready_gnt", a_gnt, 1);
    @(negedge clk);
    a_req = 0;
    check("reinit_rvalid", a_rvalid, 1);
    check("reinit_rdata", a_rdata, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 DATA_W, 8, data width of every storage word.
REQ-002 ADDR_W, 3, address width; DEPTH = 2**ADDR_W = 8 words.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 a_req  input  1  requester A access request, held until granted.
REQ-006 a_we  input  1  requester A: 1 = write, 0 = read.
REQ-007 a_addr  input  ADDR_W  requester A word address.
REQ-008 a_din  input  DATA_W  requester A write data.
REQ-009 a_gnt  output  1  requester A access accepted this cycle.
REQ-010 a_rvalid  output  1  requester A read data valid.
REQ-011 a_rdata  output  DATA_W  requester A read data.
REQ-012 b_req, b_we, b_addr, b_din, b_gnt, b_rvalid, b_rdata: same directions, widths and meanings as REQ-005..011, for requester B.
REQ-013 init_done  output  1  storage cleared; arbiter accepting requests.

Function
REQ-014 Block owns a DEPTH x DATA_W storage array; no other path accesses it.
REQ-015 States: ST_INIT, ST_READY; ST_INIT is entered on reset.
REQ-016 ST_INIT: write 0 to addresses 0..DEPTH-1, one per cycle, in ascending order (DEPTH cycles); init_done=0; a_gnt=b_gnt=0; requests ignored, not queued.
REQ-017 ST_INIT -> ST_READY at the edge that writes address DEPTH-1; init_done=1 from the next cycle until reset.
REQ-018 ST_READY: at most one grant per cycle; gnt is combinational from req in the same cycle.
REQ-019 Only one req high -> that requester is granted.
REQ-020 Both req high -> the requester selected by the priority pointer is granted; the other gets gnt=0 and keeps req high.
REQ-021 Priority pointer resets to A; after every grant it points to the non-granted requester (round-robin).
REQ-022 A requester with continuous req and no contention is granted every cycle.
REQ-023 Granted write: storage[addr] <= din at the granting edge.
REQ-024 Granted read: x_rdata = storage[addr] sampled at the granting edge; x_rvalid=1 for exactly the following cycle; latency 1.
REQ-025 x_rdata holds its last value while x_rvalid=0.
REQ-026 A read granted the cycle after a write to the same address returns the newly written data.
REQ-027 Granted writes never assert rvalid.
REQ-028 addr wraps naturally within ADDR_W bits; no out-of-range case exists.

Reset
REQ-029 While rst=1 at a posedge: state=ST_INIT, init counter=0, pointer=A, a_gnt=b_gnt=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, init_done=0.
REQ-030 Reset mid-operation aborts any in-flight read (rvalid cleared) and restarts the full clear sequence.
REQ-031 Storage contents are undefined only until ST_INIT completes.

Structure
REQ-032 Package mem_arb_pkg holds DATA_W, ADDR_W, DEPTH defaults and the state enum {ST_INIT, ST_READY}.
REQ-033 Sub-module rr_arb2 (two-way round-robin grant + priority pointer) is instantiated once; storage, init sequencer and read registers stay in mem_arbiter.

Verification
REQ-034 Reset 1 cycle, then idle -> init_done rises exactly 9 cycles after rst falls (8 clear writes plus 1); no gnt during init; all 8 words read back 0x00.
REQ-035 A writes addr i with i*16+5 for i=0..7 (no contention), then reads 0..7 -> gnt every cycle; rdata 0x05,0x15,...,0x75 each one cycle after grant.
REQ-036 A and B both request continuously -> grants alternate A,B,A,B starting with A after reset.
REQ-037 A writes 0xAA to addr 3; next cycle B reads addr 3 -> b_rvalid=1 with b_rdata=0xAA one cycle later; a_rvalid stays 0.
REQ-038 A read granted, rst asserted the next edge -> a_rvalid=0, a_rdata=0, init_done=0; re-clear completes; addr 3 reads 0x00.
REQ-039 a_req asserted during ST_INIT and held -> first a_gnt in the first ST_READY cycle.
